// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
package hilo_pkg;
  localparam int HILO_W           = 32;
  localparam int MULT_LATENCY_DEF = 34;
  localparam int CNT_W            = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural storage: product capture beats mthi/mtlo writes.
// Optional HILO_FWD_EN forwards the multiplier halves onto hi/lo during capture.
module hilo_regs
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capt,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (capt) begin
      hi_q <= mult_hi;
      lo_q <= mult_lo;
    end else begin
      if (hi_we) hi_q <= wr_data;
      if (lo_we) lo_q <= wr_data;
    end
  end

`ifdef HILO_FWD_EN
  assign hi = capt ? mult_hi : hi_q;
  assign lo = capt ? mult_lo : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif
endmodule

// File: rtl/hilo_ctrl.sv
// Multiply sequencer: launches and times the iterative multiplier, captures the product into HI/LO.
// Build option HILO_FWD_EN forwards the product onto hi/lo one cycle early (in CAPT).
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int WIDTH        = HILO_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic             mult_init,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             wr_drop
);
  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capt;

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    mult_init = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    capt      = 1'b0;
    case (state)
      IDLE: if (start) nxt = RUN;
      RUN: begin
        mult_init = 1'b1;
        busy      = 1'b1;
        if (cnt == CNT_W'(MULT_LATENCY - 1)) nxt = CAPT;
      end
      CAPT: begin
        busy = 1'b1;
        capt = 1'b1;
        nxt  = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = start ? RUN : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Counter restarts on every accepted start, including back-to-back from DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      mult_a  <= '0;
      mult_b  <= '0;
      wr_drop <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        mult_a <= op_a;
        mult_b <= op_b;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
      wr_drop <= busy && (hi_we || lo_we || start);
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_regs (
    .clk     (clk),
    .rst     (reset),
    .capt    (capt),
    .hi_we   (hi_we && !busy),
    .lo_we   (lo_we && !busy),
    .wr_data (wr_data),
    .mult_hi (mult_hi),
    .mult_lo (mult_lo),
    .hi      (hi),
    .lo      (lo)
  );
endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a behavioural signed multiplier.
module tb_hilo_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [31:0] mult_a, mult_b;
  logic        mult_init;
  logic [31:0] mult_hi, mult_lo;
  logic        hi_we, lo_we;
  logic [31:0] wr_data;
  logic [31:0] hi, lo;
  logic        busy, done, wr_drop;
  logic [63:0] prod;

  int checks = 0;
  int errors = 0;

  hilo_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_init(mult_init),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .hi_we(hi_we), .lo_we(lo_we),
    .wr_data(wr_data), .hi(hi), .lo(lo), .busy(busy), .done(done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  assign prod    = $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
  assign mult_hi = prod[63:32];
  assign mult_lo = prod[31:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    logic [31:0] capt_hi_exp;
    logic [31:0] capt_lo_exp;
    reset = 1'b1; start = 0; op_a = 0; op_b = 0; hi_we = 0; lo_we = 0; wr_data = 0;
    tick(); tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_init", {31'd0, mult_init}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_mult_a", mult_a, 0);
    reset = 1'b0;
    tick();

    // mthi / mtlo in IDLE
    hi_we = 1; wr_data = 32'hDEAD;
    tick();
    hi_we = 0;
    chk("mthi_idle", hi, 32'hDEAD);
    chk("mthi_no_drop", {31'd0, wr_drop}, 0);
    lo_we = 1; wr_data = 32'h1234;
    tick();
    lo_we = 0;
    chk("mtlo_idle", lo, 32'h1234);

    // 3 * -2 with an mtlo attempt mid-run
    op_a = 32'd3; op_b = 32'hFFFF_FFFE; start = 1;
    tick();
    start = 0;
    chk("op_a_held", mult_a, 32'd3);
    chk("op_b_held", mult_b, 32'hFFFF_FFFE);
    chk("busy_run", {31'd0, busy}, 1);
    n = 0;
    while (mult_init === 1'b1 && n < 100) begin
      n++;
      lo_we = (n == 5); wr_data = 32'hBEEF;
      tick();
      lo_we = 0;
      if (n == 5) begin
        chk("mtlo_run_drop", {31'd0, wr_drop}, 1);
        chk("mtlo_run_lo", lo, 32'h1234);
      end
    end
    chk("init_cycles", n, 34);
    chk("capt_init_low", {31'd0, mult_init}, 0);
    chk("capt_busy", {31'd0, busy}, 1);
    chk("capt_done", {31'd0, done}, 0);
`ifdef HILO_FWD_EN
    capt_hi_exp = 32'hFFFF_FFFF; capt_lo_exp = 32'hFFFF_FFFA;
`else
    capt_hi_exp = 32'hDEAD; capt_lo_exp = 32'h1234;
`endif
    chk("capt_hi", hi, capt_hi_exp);
    chk("capt_lo", lo, capt_lo_exp);
    tick();
    chk("done_pulse", {31'd0, done}, 1);
    chk("done_busy", {31'd0, busy}, 0);
    chk("prod_hi", hi, 32'hFFFF_FFFF);
    chk("prod_lo", lo, 32'hFFFF_FFFA);
    tick();
    chk("done_one_cycle", {31'd0, done}, 0);

    // back-to-back: 2*3 then 0x10000*0x10000 started from DONE
    op_a = 32'd2; op_b = 32'd3; start = 1;
    tick();
    start = 0;
    wait_done();
    chk("b2b_first_lo", lo, 32'd6);
    chk("b2b_first_hi", hi, 32'd0);
    op_a = 32'h1_0000; op_b = 32'h1_0000; start = 1;
    tick();
    start = 0;
    chk("b2b_init", {31'd0, mult_init}, 1);
    chk("b2b_mult_a", mult_a, 32'h1_0000);
    tick(); tick();
    op_a = 32'd7; start = 1;
    tick();
    start = 0;
    chk("start_run_drop", {31'd0, wr_drop}, 1);
    chk("start_run_mult_a", mult_a, 32'h1_0000);
    n = 0;
    while (mult_init === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_capt_gap", {31'd0, mult_init}, 0);
    chk("b2b_capt_busy", {31'd0, busy}, 1);
    wait_done();
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd0);
    tick();

    // asynchronous reset ten cycles into a run
    op_a = 32'd5; op_b = 32'd9; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst_init", {31'd0, mult_init}, 1);
    reset = 1'b1;
    #1;
    chk("arst_init", {31'd0, mult_init}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done === 1'b1) n++;
    end
    chk("no_done_after_rst", n, 0);
    chk("post_rst_lo", lo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
